// File: rtl/mccpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path.
// Optional build macro used by the top: MCCPU_CTRL_PERF_EN.
package mccpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWR  = 4'd6,
    S_WB     = 4'd7,
    S_BRANCH = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6
  } aluop_t;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10
  } npcop_t;

  typedef enum logic [2:0] {
    C_R,
    C_IMM,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/mccpu_decode.sv
// Combinational IR decode: Op/Funct -> instruction class + R-type ALUOp.
// Ports: op, funct in; iclass, r_aluop out.
module mccpu_decode
  import mccpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output aluop_t     r_aluop
);

  always_comb begin
    iclass  = C_ILLEGAL;
    r_aluop = ALU_NOP;
    unique case (op)
      OP_RTYPE: begin
        iclass = C_R;
        unique case (funct)
          FN_ADD, FN_ADDU: r_aluop = ALU_ADD;
          FN_SUB, FN_SUBU: r_aluop = ALU_SUB;
          FN_AND:          r_aluop = ALU_AND;
          FN_OR:           r_aluop = ALU_OR;
          FN_SLT:          r_aluop = ALU_SLT;
          FN_SLTU:         r_aluop = ALU_SLTU;
          default:         iclass  = C_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ORI: iclass = C_IMM;
      OP_LW:           iclass = C_LOAD;
      OP_SW:           iclass = C_STORE;
      OP_BEQ:          iclass = C_BRANCH;
      OP_J:            iclass = C_JUMP;
      default:         iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mccpu_ctrl.sv
// Multi-cycle sequencer: state register, next-state and strobe decode.
// In: clk, rstn, Op, Funct, Zero, mem_ready. Out: datapath strobes,
// selects, ALUOp, NPCOp, illegal, state; with MCCPU_CTRL_PERF_EN also
// cycle_cnt / instret_cnt.
module mccpu_ctrl
  import mccpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             RegWrite,
  output logic             GPRSel,
  output logic             WDSel,
  output logic             EXTOp,
  output logic             ALUSrc,
  output logic [3:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic             illegal,
`ifdef MCCPU_CTRL_PERF_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
`endif
  output logic [3:0]       state
);

  state_t  st;
  state_t  st_nx;
  iclass_t iclass;
  aluop_t  r_aluop;
  aluop_t  aop;
  npcop_t  npc;

  logic pc_wr;
  logic ir_wr;
  logic mem_wr;
  logic reg_wr;
  logic ill;

  mccpu_decode u_dec (
    .op      (Op),
    .funct   (Funct),
    .iclass  (iclass),
    .r_aluop (r_aluop)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= S_FETCH;
    else       st <= st_nx;
  end

  // Strobes follow mem_ready and Zero in the same cycle,
  // so output decode is combinational from the state.
  always_comb begin
    st_nx   = st;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    mem_wr  = 1'b0;
    reg_wr  = 1'b0;
    ill     = 1'b0;
    MemRead = 1'b0;
    IorD    = 1'b0;
    GPRSel  = 1'b0;
    WDSel   = 1'b0;
    EXTOp   = 1'b0;
    ALUSrc  = 1'b0;
    aop     = ALU_NOP;
    npc     = NPC_PLUS4;
    unique case (st)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
          st_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (iclass)
          C_R:      st_nx = S_EXEC_R;
          C_IMM:    st_nx = S_EXEC_I;
          C_LOAD,
          C_STORE:  st_nx = S_MEMADR;
          C_BRANCH: st_nx = S_BRANCH;
          C_JUMP: begin
            pc_wr = 1'b1;
            npc   = NPC_JUMP;
            st_nx = S_FETCH;
          end
          default: begin
            ill   = 1'b1;
            st_nx = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        aop   = r_aluop;
        st_nx = S_WB;
      end
      S_EXEC_I: begin
        ALUSrc = 1'b1;
        if (Op == OP_ADDI) begin
          EXTOp = 1'b1;
          aop   = ALU_ADD;
        end else begin
          aop   = ALU_OR;
        end
        st_nx = S_WB;
      end
      S_MEMADR: begin
        ALUSrc = 1'b1;
        EXTOp  = 1'b1;
        aop    = ALU_ADD;
        st_nx  = (iclass == C_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) st_nx = S_WB;
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        IorD   = 1'b1;
        if (mem_ready) st_nx = S_FETCH;
      end
      S_WB: begin
        reg_wr = 1'b1;
        GPRSel = (iclass != C_R);
        WDSel  = (iclass == C_LOAD);
        st_nx  = S_FETCH;
      end
      S_BRANCH: begin
        aop   = ALU_SUB;
        npc   = NPC_BRANCH;
        pc_wr = Zero;
        st_nx = S_FETCH;
      end
      default: st_nx = S_FETCH;
    endcase
  end

  // Write strobes are killed by reset without waiting for a clock.
  assign PCWrite  = pc_wr  & rstn;
  assign IRWrite  = ir_wr  & rstn;
  assign MemWrite = mem_wr & rstn;
  assign RegWrite = reg_wr & rstn;
  assign illegal  = ill    & rstn;
  assign ALUOp    = aop;
  assign NPCOp    = npc;
  assign state    = st;

`ifdef MCCPU_CTRL_PERF_EN
  logic retire;

  assign retire = (st == S_WB)
                | (st == S_BRANCH)
                | ((st == S_MEMWR) & mem_ready)
                | ((st == S_DECODE) & (iclass == C_JUMP));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Scoreboard bench for mccpu_ctrl: a trace model queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_mccpu_ctrl;
  import mccpu_pkg::*;

  localparam int CW = 4;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mrd, mwr, iord, rw, gsel, wsel, ext, asrc;
    logic [3:0] aop;
    logic [1:0] npc;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic rdy;
    logic zero;
    out_t o;
  } cyc_t;

  localparam int K_R = 0, K_ADDI = 1, K_ORI = 2, K_LW = 3;
  localparam int K_SW = 4, K_BEQ = 5, K_J = 6, K_ILL = 7;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [5:0] Op = '0;
  logic [5:0] Funct = '0;
  logic Zero = 1'b0;
  logic mem_ready = 1'b0;
  logic PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite;
  logic GPRSel, WDSel, EXTOp, ALUSrc, illegal;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp;
  logic [3:0] state;
`ifdef MCCPU_CTRL_PERF_EN
  logic [CW-1:0] cycle_cnt, instret_cnt;
`endif

  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;
  int retired = 0;
  int alu_of[int];
  cyc_t plan[$];
  cyc_t expq[$];
  logic [5:0] cur_op, cur_fn;

  always #5 clk = ~clk;

  mccpu_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct),
    .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite),
    .GPRSel(GPRSel), .WDSel(WDSel), .EXTOp(EXTOp),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .illegal(illegal),
`ifdef MCCPU_CTRL_PERF_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .state(state)
  );

  always @(posedge clk)
    if (!rstn) ncyc = 0;
    else       ncyc = ncyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic out_t actual();
    out_t a;
    a = '{state, PCWrite, IRWrite, MemRead, MemWrite, IorD,
          RegWrite, GPRSel, WDSel, EXTOp, ALUSrc, ALUOp,
          NPCOp, illegal};
    return a;
  endfunction

  // Monitor: one expected record per clock while a trace is running.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      cyc_t e;
      out_t a;
      e = expq.pop_front();
      a = actual();
      nchk++;
      if (a !== e.o) begin
        nerr++;
        $display("FAIL cycle st=%0d: got %h want %h @%0t",
                 e.o.st, a, e.o, $time);
      end
    end
  end

  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return alu_of.exists(int'(fn)) ? K_R : K_ILL;
    case (op)
      6'h08:   return K_ADDI;
      6'h0D:   return K_ORI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic cyc_t blank(input int s, input bit r);
    cyc_t c;
    c = '0;
    c.o.st = 4'(s);
    c.rdy = r;
    c.zero = 1'($urandom);
    return c;
  endfunction

  // Expected trace of one instruction, built from the per-state rules.
  task automatic mk(input logic [5:0] op, input logic [5:0] fn,
                    input bit z, input int wf, input int wm);
    cyc_t c;
    int k;
    k = kind(op, fn);
    cur_op = op;
    cur_fn = fn;
    plan.delete();
    repeat (wf) begin
      c = blank(0, 1'b0); c.o.mrd = 1; plan.push_back(c);
    end
    c = blank(0, 1'b1);
    c.o.mrd = 1; c.o.irw = 1; c.o.pcw = 1;
    plan.push_back(c);
    c = blank(1, 1'($urandom));
    if (k == K_J) begin c.o.pcw = 1; c.o.npc = 2'b10; end
    if (k == K_ILL) c.o.ill = 1;
    plan.push_back(c);
    case (k)
      K_R, K_ADDI, K_ORI: begin
        c = blank(k == K_R ? 2 : 3, 1'($urandom));
        c.o.asrc = (k != K_R);
        c.o.ext  = (k == K_ADDI);
        c.o.aop  = k == K_R ? 4'(alu_of[int'(fn)]) :
                   k == K_ADDI ? 4'd1 : 4'd4;
        plan.push_back(c);
        c = blank(7, 1'($urandom));
        c.o.rw = 1; c.o.gsel = (k != K_R);
        plan.push_back(c);
      end
      K_LW, K_SW: begin
        c = blank(4, 1'($urandom));
        c.o.asrc = 1; c.o.ext = 1; c.o.aop = 4'd1;
        plan.push_back(c);
        for (int i = 0; i <= wm; i++) begin
          c = blank(k == K_LW ? 5 : 6, i == wm);
          c.o.iord = 1;
          if (k == K_LW) c.o.mrd = 1;
          else           c.o.mwr = 1;
          plan.push_back(c);
        end
        if (k == K_LW) begin
          c = blank(7, 1'($urandom));
          c.o.rw = 1; c.o.gsel = 1; c.o.wsel = 1;
          plan.push_back(c);
        end
      end
      K_BEQ: begin
        c = blank(8, 1'($urandom));
        c.zero = z; c.o.aop = 4'd2; c.o.npc = 2'b01; c.o.pcw = z;
        plan.push_back(c);
      end
      default: ;
    endcase
    if (k != K_ILL) retired++;
  endtask

  // Drives the first n cycles of the plan; IR changes on entering DECODE.
  task automatic run(input int n);
    for (int i = 0; i < n && i < plan.size(); i++) begin
      mem_ready = plan[i].rdy;
      Zero = plan[i].zero;
      if (plan[i].o.st == 4'd1) begin
        Op = cur_op;
        Funct = cur_fn;
      end
      expq.push_back(plan[i]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic perf_chk();
`ifdef MCCPU_CTRL_PERF_EN
    chk("cycle_cnt", int'(cycle_cnt), ncyc % (1 << CW));
    chk("instret_cnt", int'(instret_cnt), retired % (1 << CW));
`endif
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                       input bit z, input int wf, input int wm);
    mk(op, fn, z, wf, wm);
    run(plan.size());
    perf_chk();
  endtask

  logic [5:0] ops[10];
  logic [5:0] fns[8];

  initial begin
    alu_of[32'h20] = 1; alu_of[32'h21] = 1;
    alu_of[32'h22] = 2; alu_of[32'h23] = 2;
    alu_of[32'h24] = 3; alu_of[32'h25] = 4;
    alu_of[32'h2A] = 5; alu_of[32'h2B] = 6;
    ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h04,
            6'h08, 6'h0D, 6'h23, 6'h2B, 6'h3F};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h2A, 6'h2B};

    mem_ready = 1'b1;
    Op = 6'h00;
    Funct = 6'h20;
    repeat (2) @(posedge clk);
    #1;
    chk("rst state", int'(state), 0);
    chk("rst PCWrite", int'(PCWrite), 0);
    chk("rst IRWrite", int'(IRWrite), 0);
    chk("rst wr/ill", int'({MemWrite, RegWrite, illegal}), 0);
    rstn = 1'b1;

    instr(6'h00, 6'h20, 1'b0, 0, 0);
    instr(6'h23, 6'h00, 1'b0, 0, 2);
    instr(6'h04, 6'h00, 1'b1, 0, 0);
    instr(6'h04, 6'h00, 1'b0, 0, 0);
    instr(6'h02, 6'h00, 1'b0, 0, 0);
    instr(6'h3F, 6'h00, 1'b0, 0, 0);
    instr(6'h00, 6'h3F, 1'b0, 0, 0);
    instr(6'h0D, 6'h00, 1'b0, 2, 0);
    instr(6'h08, 6'h00, 1'b0, 0, 0);
    instr(6'h2B, 6'h00, 1'b0, 0, 1);

    // sw abandoned by reset while MEMWR waits on memory.
    mk(6'h2B, 6'h00, 1'b0, 0, 3);
    retired--;
    run(3);
    mem_ready = 1'b0;
    expq.push_back(plan[3]);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    retired = 0;
    #1;
    chk("rst mid MemWrite", int'(MemWrite), 0);
    chk("rst mid state", int'(state), 0);
    chk("rst mid RegWrite", int'(RegWrite), 0);
    @(posedge clk);
    #1;
    chk("rst held state", int'(state), 0);
    rstn = 1'b1;

    repeat (5) instr(6'h0D, 6'h00, 1'b0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      instr(op, fn, 1'($urandom),
            $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
            $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
